// File: rtl/uart_pkg.sv
// Shared UART constants: reset defaults for the baud generator and legal
// configuration limits, plus the system clock frequency used by TX/RX.
package uart_pkg;

   localparam int CLK_FREQ = 100_000_000;

   localparam int DEF_DIV  = 651;
   localparam int DEF_FRAC = 1;
   localparam int DEF_OSR  = 16;

   localparam int MIN_DIV  = 2;
   localparam int MIN_OSR  = 4;

endpackage

// File: rtl/uart_frac_div.sv
// Fractional-N divider: base period of div_int or div_int+1 cycles, chosen by
// the carry of a FRAC_W-bit phase accumulator. rx_tick marks the period's last cycle.
module uart_frac_div #(
   parameter int DIV_W  = 16,
   parameter int FRAC_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   output logic              rx_tick
);

   logic [DIV_W-1:0]  cnt;
   logic [FRAC_W-1:0] acc;
   logic              carry;
   logic [DIV_W:0]    last_cnt;
   logic [FRAC_W:0]   acc_sum;

   // One extra cycle in this period when the previous period end overflowed acc.
   assign last_cnt = {1'b0, div_int} + {{DIV_W{1'b0}}, carry} - {{DIV_W{1'b0}}, 1'b1};
   assign acc_sum  = {1'b0, acc} + {1'b0, div_frac};
   assign rx_tick  = en & ~clr & ({1'b0, cnt} == last_cnt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         acc   <= '0;
         carry <= 1'b0;
      end else if (clr || !en) begin
         cnt   <= '0;
         acc   <= '0;
         carry <= 1'b0;
      end else if (rx_tick) begin
         cnt   <= '0;
         acc   <= acc_sum[FRAC_W-1:0];
         carry <= acc_sum[FRAC_W];
      end else begin
         cnt   <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_baud_tick_gen.sv
// Baud/oversample strobe generator: run-time loadable, range-checked divisor and
// oversample ratio; registered rx/mid/tx strobes used as clock enables on clk.
module uart_baud_tick_gen #(
   parameter int DIV_W    = 16,
   parameter int FRAC_W   = 4,
   parameter int OSR_W    = 6,
   parameter int DEF_DIV  = uart_pkg::DEF_DIV,
   parameter int DEF_FRAC = uart_pkg::DEF_FRAC,
   parameter int DEF_OSR  = uart_pkg::DEF_OSR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              cfg_load,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic [OSR_W-1:0]  osr,
   output logic              rx_tick,
   output logic              tx_tick,
   output logic              mid_tick,
   output logic              cfg_err
);

   import uart_pkg::*;

   logic [DIV_W-1:0]  div_q;
   logic [FRAC_W-1:0] frac_q;
   logic [OSR_W-1:0]  osr_q;
   logic [OSR_W-1:0]  os_cnt;
   logic              cfg_ok;
   logic              load_ok;
   logic              period_end;
   logic              os_last;
   logic              os_mid;

   assign cfg_ok  = (div_int >= DIV_W'(MIN_DIV)) && (osr >= OSR_W'(MIN_OSR));
   assign load_ok = cfg_load & cfg_ok;
   assign os_last = (os_cnt == osr_q - OSR_W'(1));
   assign os_mid  = (os_cnt == (osr_q >> 1) - OSR_W'(1));

   uart_frac_div #(
      .DIV_W  (DIV_W),
      .FRAC_W (FRAC_W)
   ) u_frac_div (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clr      (load_ok),
      .div_int  (div_q),
      .div_frac (frac_q),
      .rx_tick  (period_end)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q    <= DIV_W'(DEF_DIV);
         frac_q   <= FRAC_W'(DEF_FRAC);
         osr_q    <= OSR_W'(DEF_OSR);
         cfg_err  <= 1'b0;
         os_cnt   <= '0;
         rx_tick  <= 1'b0;
         tx_tick  <= 1'b0;
         mid_tick <= 1'b0;
      end else begin
         if (cfg_load) begin
            if (cfg_ok) begin
               div_q   <= div_int;
               frac_q  <= div_frac;
               osr_q   <= osr;
               cfg_err <= 1'b0;
            end else begin
               cfg_err <= 1'b1;
            end
         end

         // An accepted load resyncs the bit phase and drops any strobe due this edge.
         if (load_ok || !en) begin
            os_cnt   <= '0;
            rx_tick  <= 1'b0;
            tx_tick  <= 1'b0;
            mid_tick <= 1'b0;
         end else begin
            rx_tick  <= period_end;
            tx_tick  <= period_end & os_last;
            mid_tick <= period_end & os_mid;
            if (period_end) begin
               os_cnt <= os_last ? '0 : os_cnt + OSR_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// Directed bench for uart_baud_tick_gen: tick periods, bit/centre strobes,
// fractional averaging, config rejection, enable gating and async reset.
module tb_uart_baud_tick_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        cfg_load;
   logic [15:0] div_int;
   logic [3:0]  div_frac;
   logic [5:0]  osr;
   logic        rx_tick;
   logic        tx_tick;
   logic        mid_tick;
   logic        cfg_err;

   int n_checks = 0;
   int n_fail   = 0;
   int fr_acc   = 0;
   int fr_c     = 0;

   uart_baud_tick_gen dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .cfg_load (cfg_load),
      .div_int  (div_int),
      .div_frac (div_frac),
      .osr      (osr),
      .rx_tick  (rx_tick),
      .tx_tick  (tx_tick),
      .mid_tick (mid_tick),
      .cfg_err  (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int d, input int f, input int o);
      div_int  = 16'(d);
      div_frac = 4'(f);
      osr      = 6'(o);
      cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
   endtask

   // Cycles until the next rx_tick sample; -1 when the bound expires.
   task automatic wait_rx(input int limit, output int n);
      n = 0;
      forever begin
         step();
         n++;
         if (rx_tick === 1'b1) break;
         if (n >= limit) begin
            n = -1;
            break;
         end
      end
   endtask

   // Advances the fractional model by one period; returns that period's length.
   task automatic frac_model(input int d, input int f, output int p);
      int t;
      p      = d + fr_c;
      t      = fr_acc + f;
      fr_c   = (t >= 16) ? 1 : 0;
      fr_acc = t % 16;
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b0; en = 1'b0; cfg_load = 1'b0;
      div_int = '0; div_frac = '0; osr = '0;
      repeat (3) step();
      n_checks++; if (rx_tick !== 1'b0)  begin n_fail++; $display("FAIL reset_rx: got %b expected 0", rx_tick); end
      n_checks++; if (tx_tick !== 1'b0)  begin n_fail++; $display("FAIL reset_tx: got %b expected 0", tx_tick); end
      n_checks++; if (mid_tick !== 1'b0) begin n_fail++; $display("FAIL reset_mid: got %b expected 0", mid_tick); end
      n_checks++; if (cfg_err !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
      rst = 1'b1;
      bad = 0;
      repeat (10) begin
         step();
         if (rx_tick || tx_tick || mid_tick) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_no_ticks: got %0d ticks expected 0", bad); end
   endtask

   task automatic test_defaults();
      int n;
      en = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         wait_rx(700, n);
         n_checks++; if (n !== ((i == 17) ? 652 : 651)) begin n_fail++; $display("FAIL def_period[%0d]: got %0d expected %0d", i, n, (i == 17) ? 652 : 651); end
         n_checks++; if (tx_tick !== (i == 16)) begin n_fail++; $display("FAIL def_tx[%0d]: got %b expected %b", i, tx_tick, i == 16); end
         n_checks++; if (mid_tick !== (i == 8)) begin n_fail++; $display("FAIL def_mid[%0d]: got %b expected %b", i, mid_tick, i == 8); end
      end
      n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL def_err: got %b expected 0", cfg_err); end
   endtask

   task automatic test_load_basic();
      int n;
      load(4, 0, 4);
      n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", cfg_err); end
      n_checks++; if (rx_tick !== 1'b0) begin n_fail++; $display("FAIL basic_load_rx: got %b expected 0", rx_tick); end
      for (int i = 1; i <= 8; i++) begin
         wait_rx(10, n);
         n_checks++; if (n !== 4) begin n_fail++; $display("FAIL basic_period[%0d]: got %0d expected 4", i, n); end
         n_checks++; if (tx_tick !== (i % 4 == 0)) begin n_fail++; $display("FAIL basic_tx[%0d]: got %b expected %b", i, tx_tick, i % 4 == 0); end
         n_checks++; if (mid_tick !== (i % 4 == 2)) begin n_fail++; $display("FAIL basic_mid[%0d]: got %b expected %b", i, mid_tick, i % 4 == 2); end
      end
   endtask

   task automatic test_frac();
      int n;
      int p;
      int sum;
      load(4, 8, 4);
      fr_acc = 0; fr_c = 0; sum = 0;
      for (int i = 1; i <= 101; i++) begin
         wait_rx(10, n);
         frac_model(4, 8, p);
         if (i >= 2) sum += n;
         n_checks++; if (n !== p) begin n_fail++; $display("FAIL frac_period[%0d]: got %0d expected %0d", i, n, p); end
      end
      n_checks++; if (sum !== 450) begin n_fail++; $display("FAIL frac_sum100: got %0d expected 450", sum); end
   endtask

   task automatic test_reject();
      int n;
      int p;
      load(1, 0, 4);
      n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL rej_div_err: got %b expected 1", cfg_err); end
      wait_rx(10, n);
      frac_model(4, 8, p);
      n_checks++; if (n !== p - 1) begin n_fail++; $display("FAIL rej_keep_period: got %0d expected %0d", n, p - 1); end
      wait_rx(10, n);
      frac_model(4, 8, p);
      n_checks++; if (n !== p) begin n_fail++; $display("FAIL rej_keep_period2: got %0d expected %0d", n, p); end
      n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL rej_err_sticky: got %b expected 1", cfg_err); end
      load(2, 0, 3);
      n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL rej_osr_err: got %b expected 1", cfg_err); end
      load(2, 0, 4);
      n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL min_cfg_err: got %b expected 0", cfg_err); end
      for (int i = 1; i <= 4; i++) begin
         wait_rx(10, n);
         n_checks++; if (n !== 2) begin n_fail++; $display("FAIL min_period[%0d]: got %0d expected 2", i, n); end
         n_checks++; if (tx_tick !== (i == 4)) begin n_fail++; $display("FAIL min_tx[%0d]: got %b expected %b", i, tx_tick, i == 4); end
         n_checks++; if (mid_tick !== (i == 2)) begin n_fail++; $display("FAIL min_mid[%0d]: got %b expected %b", i, mid_tick, i == 2); end
      end
      load(3, 0, 4);
      n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL d3_err: got %b expected 0", cfg_err); end
      for (int i = 1; i <= 4; i++) begin
         wait_rx(10, n);
         n_checks++; if (n !== 3) begin n_fail++; $display("FAIL d3_period[%0d]: got %0d expected 3", i, n); end
         n_checks++; if (tx_tick !== (i == 4)) begin n_fail++; $display("FAIL d3_tx[%0d]: got %b expected %b", i, tx_tick, i == 4); end
      end
   endtask

   task automatic test_en_drop();
      int n;
      int bad;
      load(4, 0, 4);
      for (int i = 1; i <= 2; i++) begin
         wait_rx(10, n);
         n_checks++; if (n !== 4) begin n_fail++; $display("FAIL pre_drop_period[%0d]: got %0d expected 4", i, n); end
      end
      en = 1'b0;
      bad = 0;
      repeat (20) begin
         step();
         if (rx_tick || tx_tick || mid_tick) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL en_low_ticks: got %0d expected 0", bad); end
      en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         wait_rx(10, n);
         n_checks++; if (n !== 4) begin n_fail++; $display("FAIL reen_period[%0d]: got %0d expected 4", i, n); end
         n_checks++; if (tx_tick !== (i == 4)) begin n_fail++; $display("FAIL reen_tx[%0d]: got %b expected %b", i, tx_tick, i == 4); end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      load(0, 0, 4);
      n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL rst_pre_err: got %b expected 1", cfg_err); end
      for (int i = 0; i < 8; i++) begin
         wait_rx(10, n);
         if (tx_tick === 1'b1 || n < 0) break;
      end
      n_checks++; if (tx_tick !== 1'b1) begin n_fail++; $display("FAIL rst_find_tx: got %b expected 1", tx_tick); end
      rst = 1'b0;
      #1;
      n_checks++; if (rx_tick !== 1'b0)  begin n_fail++; $display("FAIL rst_async_rx: got %b expected 0", rx_tick); end
      n_checks++; if (tx_tick !== 1'b0)  begin n_fail++; $display("FAIL rst_async_tx: got %b expected 0", tx_tick); end
      n_checks++; if (mid_tick !== 1'b0) begin n_fail++; $display("FAIL rst_async_mid: got %b expected 0", mid_tick); end
      n_checks++; if (cfg_err !== 1'b0)  begin n_fail++; $display("FAIL rst_async_err: got %b expected 0", cfg_err); end
      #1;
      rst = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         wait_rx(700, n);
         n_checks++; if (n !== 651) begin n_fail++; $display("FAIL rst_def_period[%0d]: got %0d expected 651", i, n); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_defaults();
      test_load_basic();
      test_frac();
      test_reject();
      test_en_drop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_baud_tick_gen.md
# uart_baud_tick_gen

Parametrised baud/oversample tick generator for the UART TX and RX paths.
- Produces a one-cycle oversample strobe and a one-cycle bit strobe, replacing free-running toggled clocks.
- The divisor has an integer and a fractional part, so odd clock/baud ratios average out exactly.
- Configuration is run-time loadable and range-checked.
- Sits between the CSR block and the UART transmitter/receiver; both consume its strobes as clock enables on the system clock.

## Interface
Parameters:
- DIV_W, 16: width of integer divisor.
- FRAC_W, 4: width of fractional divisor (units of 1/2^FRAC_W cycle).
- OSR_W, 6: width of oversample-ratio field.
- DEF_DIV, 651: reset integer divisor (100 MHz, 9600 baud, x16).
- DEF_FRAC, 1: reset fractional divisor.
- DEF_OSR, 16: reset oversample ratio.

Ports:
- clk, in, 1: system clock; one clock domain.
- rst, in, 1: asynchronous, active-low reset.
- en, in, 1: run enable; low holds all counters cleared.
- cfg_load, in, 1: one-cycle strobe; capture div_int/div_frac/osr.
- div_int, in, DIV_W: integer cycles per oversample tick; legal >= 2.
- div_frac, in, FRAC_W: fractional cycles per oversample tick.
- osr, in, OSR_W: oversample ticks per bit; legal 4..2^OSR_W-1.
- rx_tick, out, 1: oversample strobe, one cycle.
- tx_tick, out, 1: bit strobe, one cycle; coincides with the last rx_tick of a bit.
- mid_tick, out, 1: bit-centre strobe; coincides with the rx_tick where os_cnt == osr/2 - 1 (integer division).
- cfg_err, out, 1: set when the last cfg_load was rejected.

## Operation
- Shadow registers hold div_int, div_frac and osr.
  - Reset values are DEF_DIV, DEF_FRAC and DEF_OSR.
  - They are updated only by an accepted cfg_load.
- cfg_load is rejected if div_int < 2 or osr < 4.
  - On reject: shadow is unchanged and cfg_err is set.
  - On accept: shadow is written and cfg_err is cleared.
  - cfg_err stays asserted until the next accepted load.
- Base counter:
  - Counts 0..P-1, where P = div_int, or div_int+1 when the carry flag is set.
  - rx_tick is asserted in the cycle where the counter equals P-1.
- Fractional accumulator (FRAC_W bits, starts at 0):
  - At each period end, acc <= acc + div_frac.
  - The carry-out becomes the carry flag for the next period.
  - Mean period = div_int + div_frac/2^FRAC_W cycles.
- Oversample counter os_cnt:
  - Counts 0..osr-1 and advances on rx_tick.
  - tx_tick = rx_tick AND os_cnt == osr-1, after which os_cnt wraps to 0.
- en low: base counter, acc, carry and os_cnt are held at 0, and all tick outputs are 0.
- An accepted cfg_load clears base counter, acc, carry and os_cnt (resync), whether en is high or low.
  - A rejected load does not disturb the counters.
- cfg_load takes priority over counting in the same cycle.
  - Counting resumes on the next cycle using the new shadow values.

## Timing
- All outputs are registered.
- Reset values: rx_tick=0, tx_tick=0, mid_tick=0, cfg_err=0, all counters 0.
- en sampled high at edge 0 with carry=0: the first rx_tick is high during the cycle after edge div_int-1 and lasts exactly one cycle.
- rx_tick spacing: exactly div_int or div_int+1 cycles.
  - Never two rx_ticks closer than 2 cycles (div_int >= 2 is guaranteed).
- tx_tick period is the sum of osr base periods.
- mid_tick and tx_tick are never asserted together, since osr >= 4.
- cfg_load at edge k: the new shadow and cfg_err are visible after edge k; ticks pending at edge k are dropped.
- en dropping mid-bit: ticks stop the next cycle; no partial tx_tick is emitted.
- Reset asserted mid-operation: all outputs go to 0 immediately (async); the shadow returns to the DEF_* values.

## Structure
- Package uart_pkg holds:
  - DEF_DIV, DEF_FRAC and DEF_OSR defaults.
  - The minimum legal divisor (2) and minimum legal oversample ratio (4).
  - The CLK_FREQ constant (100_000_000), shared with the UART TX/RX blocks.
- Sub-module uart_frac_div contains the base counter, fractional accumulator and carry.
  - Its inputs are en, clr, div_int and div_frac; its output is rx_tick.
- The top level holds the shadow registers, config check, os_cnt and strobe decode.

## Test plan
- Reset, then en=1 with the defaults: the rx_tick period is 651 cycles, with a 652-cycle period once every 16 ticks; tx_tick occurs every 16 rx_ticks; cfg_err=0.
- Load div_int=4, div_frac=0, osr=4: rx_tick every 4 cycles, tx_tick every 16 cycles, mid_tick on os_cnt=1 (8 cycles before tx_tick).
- Load div_int=4, div_frac=8 (FRAC_W=4), osr=4: rx_tick periods are 4,4,5,4,5,4,5…; the mean over 100 ticks is 4.5.
- Load div_int=1: cfg_err=1 and the old configuration keeps ticking unchanged. Then load div_int=3, osr=4: cfg_err=0 and counters resync, with the first rx_tick 3 cycles after the load.
- Drop en mid-bit after the 2nd rx_tick: no ticks while en is low. Re-enable: the first rx_tick comes div_int cycles later, and tx_tick requires a full osr ticks.
- Assert rst in the cycle of a tx_tick: all outputs are 0 at once; after release with en=1, the timing restarts from the defaults.
